// File: rtl/blast_hit_pkg.sv
// Shared types for the seed-hit collector and the ungapped-extension stage.
// Holds the collector FSM states, base packing and the reference record layout.
package blast_hit_pkg;

   typedef enum logic [1:0] {
      IDLE,
      PUSH,
      WAIT_LOW
   } state_t;

   // 512-bit database word holds 256 two-bit bases
   localparam int BASES_PER_WORD = 256;

   // Reference layout for the default widths (QLOC_W=9, DBIDX_W=32)
   localparam int QPOS_W  = 8;
   localparam int DBPOS_W = 32;
   localparam int REC_W   = QPOS_W + DBPOS_W;

   typedef struct packed {
      logic [QPOS_W-1:0]  qpos;
      logic [DBPOS_W-1:0] dbpos;
   } hit_rec_t;

endpackage

// File: rtl/hit_fifo.sv
// Synchronous first-word-fall-through FIFO with clear, full/empty and count.
// Ports: push/wdata write, pop reads head (rdata), clear flushes; rdata is 0 when empty.
module hit_fifo #(
   parameter int DEPTH = 16,
   parameter int WIDTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     clear,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         wdata,
   output logic [WIDTH-1:0]         rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [AW-1:0]    wr_q, wr_d;
   logic [AW-1:0]    rd_q, rd_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             do_push;
   logic             do_pop;

   assign empty = (cnt_q == '0);
   assign full  = (cnt_q == CW'(DEPTH));
   assign count = cnt_q;
   assign rdata = empty ? '0 : mem_q[rd_q];

   always_comb begin
      do_pop  = pop && !empty;
      // a pop on the same edge frees the slot a full FIFO needs
      do_push = push && (!full || do_pop);
      mem_d   = mem_q;
      wr_d    = wr_q;
      rd_d    = rd_q;
      cnt_d   = cnt_q;
      if (clear) begin
         wr_d  = '0;
         rd_d  = '0;
         cnt_d = '0;
      end else begin
         if (do_push) begin
            mem_d[wr_q] = wdata;
            wr_d        = wr_q + AW'(1);
         end
         if (do_pop) begin
            rd_d = rd_q + AW'(1);
         end
         unique case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mem_q <= '{default: '0};
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         mem_q <= mem_d;
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/hit_collector.sv
// Captures seed hits, converts them to {qpos, dbpos} records, pulses stop to the
// detector and queues records for extension. Ports: hit_in/loc/shift/word in,
// stop_out/location_end_out back, rec_* valid/ready out, fifo_full, hit_count.
module hit_collector
   import blast_hit_pkg::*;
#(
   parameter int DEPTH   = 16,
   parameter int QLOC_W  = 9,
   parameter int DBIDX_W = 32,
   parameter int CNT_W   = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               clear,
   input  logic               hit_in,
   input  logic [QLOC_W-1:0]  loc_q_in,
   input  logic [QLOC_W-1:0]  shift_no_in,
   input  logic [DBIDX_W-1:0] db_word_idx,
   output logic               stop_out,
   output logic [31:0]        location_end_out,
   output logic               rec_valid,
   input  logic               rec_ready,
   output logic [QLOC_W-2:0]  rec_qpos,
   output logic [DBIDX_W-1:0] rec_dbpos,
   output logic               fifo_full,
   output logic [CNT_W-1:0]   hit_count
);

   typedef struct packed {
      logic [QLOC_W-2:0]  qpos;
      logic [DBIDX_W-1:0] dbpos;
   } rec_t;

   localparam int RW = $bits(rec_t);

   state_t             state_q, state_d;
   logic [QLOC_W-2:0]  qpos_q, qpos_d;
   logic [DBIDX_W-1:0] dbpos_q, dbpos_d;
   logic [QLOC_W-1:0]  resume_q, resume_d;
   logic               stop_q, stop_d;
   logic [31:0]        loc_end_q, loc_end_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;

   logic               push;
   logic               pop;
   logic               f_full;
   logic               f_empty;
   logic [$clog2(DEPTH):0] f_count;
   rec_t               wrec;
   rec_t               hrec;
   logic [RW-1:0]      hrec_bits;

   assign rec_valid = (f_count != '0);
   assign pop       = !f_empty && rec_ready;
   assign wrec      = '{qpos: qpos_q, dbpos: dbpos_q};
   assign hrec      = rec_t'(hrec_bits);

   assign rec_qpos         = hrec.qpos;
   assign rec_dbpos        = hrec.dbpos;
   assign fifo_full        = f_full;
   assign stop_out         = stop_q;
   assign location_end_out = loc_end_q;
   assign hit_count        = cnt_q;

   always_comb begin
      state_d   = state_q;
      qpos_d    = qpos_q;
      dbpos_d   = dbpos_q;
      resume_d  = resume_q;
      stop_d    = 1'b0;
      loc_end_d = loc_end_q;
      cnt_d     = cnt_q;
      push      = 1'b0;
      if (clear) begin
         state_d = IDLE;
         cnt_d   = '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (hit_in) begin
                  // locations are bit offsets of 2-bit bases
                  qpos_d   = (QLOC_W-1)'(loc_q_in >> 1);
                  dbpos_d  = db_word_idx * DBIDX_W'(BASES_PER_WORD)
                           + DBIDX_W'(shift_no_in >> 1);
                  resume_d = shift_no_in + QLOC_W'(2);
                  state_d  = PUSH;
               end
            end
            PUSH: begin
               // without space the detector stays stalled on hit
               if (!f_full || pop) begin
                  push      = 1'b1;
                  stop_d    = 1'b1;
                  loc_end_d = 32'(resume_q);
                  if (cnt_q != {CNT_W{1'b1}}) begin
                     cnt_d = cnt_q + CNT_W'(1);
                  end
                  state_d   = WAIT_LOW;
               end
            end
            WAIT_LOW: begin
               // one record per hit pulse, however long it is held
               if (!hit_in) begin
                  state_d = IDLE;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= IDLE;
         qpos_q    <= '0;
         dbpos_q   <= '0;
         resume_q  <= '0;
         stop_q    <= 1'b0;
         loc_end_q <= '0;
         cnt_q     <= '0;
      end else begin
         state_q   <= state_d;
         qpos_q    <= qpos_d;
         dbpos_q   <= dbpos_d;
         resume_q  <= resume_d;
         stop_q    <= stop_d;
         loc_end_q <= loc_end_d;
         cnt_q     <= cnt_d;
      end
   end

   hit_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (RW)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .clear (clear),
      .push  (push),
      .pop   (pop),
      .wdata (wrec),
      .rdata (hrec_bits),
      .full  (f_full),
      .empty (f_empty),
      .count (f_count)
   );

endmodule

// File: tb/tb_hit_collector.sv
// Directed bench for hit_collector built with a 4-entry FIFO.
// Each scenario task drives hits and compares outputs against hand-worked values.
module tb_hit_collector;

   localparam int QW = 9;
   localparam int DW = 32;
   localparam int CW = 32;
   localparam int DP = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          clear = 1'b0;
   logic          hit_in = 1'b0;
   logic [QW-1:0] loc_q_in = '0;
   logic [QW-1:0] shift_no_in = '0;
   logic [DW-1:0] db_word_idx = '0;
   logic          rec_ready = 1'b0;
   logic          stop_out;
   logic [31:0]   location_end_out;
   logic          rec_valid;
   logic [QW-2:0] rec_qpos;
   logic [DW-1:0] rec_dbpos;
   logic          fifo_full;
   logic [CW-1:0] hit_count;

   int vecs = 0;
   int errs = 0;
   int stops = 0;
   int pops = 0;

   hit_collector #(
      .DEPTH   (DP),
      .QLOC_W  (QW),
      .DBIDX_W (DW),
      .CNT_W   (CW)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .clear            (clear),
      .hit_in           (hit_in),
      .loc_q_in         (loc_q_in),
      .shift_no_in      (shift_no_in),
      .db_word_idx      (db_word_idx),
      .stop_out         (stop_out),
      .location_end_out (location_end_out),
      .rec_valid        (rec_valid),
      .rec_ready        (rec_ready),
      .rec_qpos         (rec_qpos),
      .rec_dbpos        (rec_dbpos),
      .fifo_full        (fifo_full),
      .hit_count        (hit_count)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (stop_out) stops++;
      if (rec_valid && rec_ready) pops++;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_clear();
      clear = 1'b1;
      tick();
      clear = 1'b0;
   endtask

   // edges = number of edges from raising hit_in until stop_out seen (0 = none)
   task automatic do_hit(input logic [QW-1:0] l, input logic [QW-1:0] s,
                         input logic [DW-1:0] w, output int edges);
      loc_q_in = l;
      shift_no_in = s;
      db_word_idx = w;
      hit_in = 1'b1;
      edges = 0;
      for (int i = 1; i <= 6; i++) begin
         tick();
         if (stop_out) begin
            edges = i;
            break;
         end
      end
      hit_in = 1'b0;
      tick();
   endtask

   task automatic test_reset();
      #2;
      if ({stop_out, location_end_out, rec_valid, rec_qpos, rec_dbpos,
           fifo_full, hit_count} !== '0) begin
         errs++;
         $display("FAIL reset_outputs: got stop=%0d lend=%0d valid=%0d cnt=%0d want all 0",
                  stop_out, location_end_out, rec_valid, hit_count);
      end
      vecs++;
      #5;
      rst = 1'b1;
      tick();
   endtask

   task automatic test_single();
      int s0;
      s0 = stops;
      rec_ready = 1'b1;
      loc_q_in = 9'd10;
      shift_no_in = 9'd6;
      db_word_idx = 32'd3;
      hit_in = 1'b1;
      tick();
      if (stop_out !== 1'b0) begin
         errs++; $display("FAIL single_capture_stop: got %0d want 0", stop_out);
      end
      vecs++;
      tick();
      if (stop_out !== 1'b1) begin
         errs++; $display("FAIL single_stop: got %0d want 1", stop_out);
      end
      vecs++;
      if (location_end_out !== 32'd8) begin
         errs++; $display("FAIL single_lend: got %0d want 8", location_end_out);
      end
      vecs++;
      if (rec_valid !== 1'b1 || rec_qpos !== 8'd5 || rec_dbpos !== 32'd771) begin
         errs++;
         $display("FAIL single_rec: got v=%0d q=%0d d=%0d want v=1 q=5 d=771",
                  rec_valid, rec_qpos, rec_dbpos);
      end
      vecs++;
      if (hit_count !== 32'd1) begin
         errs++; $display("FAIL single_count: got %0d want 1", hit_count);
      end
      vecs++;
      hit_in = 1'b0;
      tick();
      if (stop_out !== 1'b0 || rec_valid !== 1'b0) begin
         errs++;
         $display("FAIL single_after: got stop=%0d valid=%0d want 0 0", stop_out, rec_valid);
      end
      vecs++;
      if (stops - s0 !== 1) begin
         errs++; $display("FAIL single_pulses: got %0d want 1", stops - s0);
      end
      vecs++;
      rec_ready = 1'b0;
   endtask

   task automatic test_hold();
      int s0, p0;
      do_clear();
      s0 = stops;
      p0 = pops;
      rec_ready = 1'b1;
      loc_q_in = 9'd20;
      shift_no_in = 9'd40;
      db_word_idx = 32'd1;
      hit_in = 1'b1;
      repeat (10) tick();
      hit_in = 1'b0;
      repeat (2) tick();
      if (stops - s0 !== 1) begin
         errs++; $display("FAIL hold_pulses: got %0d want 1", stops - s0);
      end
      vecs++;
      if (pops - p0 !== 1) begin
         errs++; $display("FAIL hold_records: got %0d want 1", pops - p0);
      end
      vecs++;
      if (hit_count !== 32'd1 || location_end_out !== 32'd42) begin
         errs++;
         $display("FAIL hold_state: got cnt=%0d lend=%0d want 1 42", hit_count, location_end_out);
      end
      vecs++;
      rec_ready = 1'b0;
   endtask

   task automatic test_full();
      int e, s0;
      do_clear();
      rec_ready = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         do_hit(QW'(2 * k), QW'(4 * k), DW'(k), e);
         if (e !== 2) begin
            errs++; $display("FAIL full_hit%0d_latency: got %0d want 2", k, e);
         end
         vecs++;
      end
      if (fifo_full !== 1'b1 || hit_count !== 32'd4 || rec_qpos !== 8'd1) begin
         errs++;
         $display("FAIL full_fill: got full=%0d cnt=%0d q=%0d want 1 4 1",
                  fifo_full, hit_count, rec_qpos);
      end
      vecs++;
      s0 = stops;
      loc_q_in = 9'd10;
      shift_no_in = 9'd20;
      db_word_idx = 32'd5;
      hit_in = 1'b1;
      repeat (5) tick();
      if (stops !== s0 || fifo_full !== 1'b1 || hit_count !== 32'd4) begin
         errs++;
         $display("FAIL full_stall: got pulses=%0d full=%0d cnt=%0d want 0 1 4",
                  stops - s0, fifo_full, hit_count);
      end
      vecs++;
      rec_ready = 1'b1;
      tick();
      rec_ready = 1'b0;
      if (stop_out !== 1'b1 || fifo_full !== 1'b1 || hit_count !== 32'd5) begin
         errs++;
         $display("FAIL full_swap: got stop=%0d full=%0d cnt=%0d want 1 1 5",
                  stop_out, fifo_full, hit_count);
      end
      vecs++;
      if (rec_qpos !== 8'd2 || rec_dbpos !== 32'd516 || location_end_out !== 32'd22) begin
         errs++;
         $display("FAIL full_head: got q=%0d d=%0d lend=%0d want 2 516 22",
                  rec_qpos, rec_dbpos, location_end_out);
      end
      vecs++;
      hit_in = 1'b0;
      tick();
      rec_ready = 1'b1;
      for (int k = 3; k <= 5; k++) begin
         tick();
         if (rec_qpos !== 8'(k) || rec_dbpos !== DW'(k * 256 + 2 * k)) begin
            errs++;
            $display("FAIL drain_%0d: got q=%0d d=%0d want %0d %0d",
                     k, rec_qpos, rec_dbpos, k, k * 256 + 2 * k);
         end
         vecs++;
      end
      tick();
      if (rec_valid !== 1'b0 || fifo_full !== 1'b0) begin
         errs++;
         $display("FAIL drain_empty: got valid=%0d full=%0d want 0 0", rec_valid, fifo_full);
      end
      vecs++;
      rec_ready = 1'b0;
   endtask

   task automatic test_wrap();
      int e;
      do_clear();
      do_hit(9'd0, 9'd510, 32'd0, e);
      if (e !== 2 || location_end_out !== 32'd0) begin
         errs++;
         $display("FAIL wrap_resume: got edges=%0d lend=%0d want 2 0", e, location_end_out);
      end
      vecs++;
      if (rec_qpos !== 8'd0 || rec_dbpos !== 32'd255) begin
         errs++;
         $display("FAIL wrap_dbpos: got q=%0d d=%0d want 0 255", rec_qpos, rec_dbpos);
      end
      vecs++;
      do_hit(9'd4, 9'd2, 32'hFFFF_FFFF, e);
      if (location_end_out !== 32'd4) begin
         errs++; $display("FAIL trunc_resume: got %0d want 4", location_end_out);
      end
      vecs++;
      rec_ready = 1'b1;
      tick();
      rec_ready = 1'b0;
      if (rec_qpos !== 8'd2 || rec_dbpos !== 32'hFFFF_FF01) begin
         errs++;
         $display("FAIL trunc_dbpos: got q=%0d d=%h want 2 ffffff01", rec_qpos, rec_dbpos);
      end
      vecs++;
   endtask

   task automatic test_clear();
      int e;
      do_clear();
      for (int k = 1; k <= 3; k++) begin
         do_hit(QW'(2 * k), QW'(4 * k), DW'(k), e);
      end
      if (hit_count !== 32'd3 || rec_valid !== 1'b1) begin
         errs++;
         $display("FAIL clear_pre: got cnt=%0d valid=%0d want 3 1", hit_count, rec_valid);
      end
      vecs++;
      do_clear();
      if (rec_valid !== 1'b0 || hit_count !== 32'd0 || stop_out !== 1'b0) begin
         errs++;
         $display("FAIL clear_flush: got valid=%0d cnt=%0d stop=%0d want 0 0 0",
                  rec_valid, hit_count, stop_out);
      end
      vecs++;
      do_hit(9'd6, 9'd8, 32'd2, e);
      if (e !== 2 || rec_qpos !== 8'd3 || rec_dbpos !== 32'd516 || hit_count !== 32'd1) begin
         errs++;
         $display("FAIL clear_resume: got e=%0d q=%0d d=%0d cnt=%0d want 2 3 516 1",
                  e, rec_qpos, rec_dbpos, hit_count);
      end
      vecs++;
   endtask

   task automatic test_rst_mid_push();
      int e, s0;
      do_clear();
      for (int k = 1; k <= 4; k++) begin
         do_hit(QW'(2 * k), QW'(4 * k), DW'(k), e);
      end
      hit_in = 1'b1;
      repeat (3) tick();
      if (fifo_full !== 1'b1) begin
         errs++; $display("FAIL rst_pre_full: got %0d want 1", fifo_full);
      end
      vecs++;
      #3;
      rst = 1'b0;
      #1;
      if ({stop_out, location_end_out, rec_valid, rec_qpos, rec_dbpos,
           fifo_full, hit_count} !== '0) begin
         errs++;
         $display("FAIL rst_async: got lend=%0d valid=%0d full=%0d cnt=%0d want all 0",
                  location_end_out, rec_valid, fifo_full, hit_count);
      end
      vecs++;
      hit_in = 1'b0;
      #2;
      rst = 1'b1;
      tick();
      s0 = stops;
      do_hit(9'd8, 9'd10, 32'd5, e);
      if (e !== 2 || stops - s0 !== 1 || location_end_out !== 32'd12) begin
         errs++;
         $display("FAIL rst_after_stop: got e=%0d pulses=%0d lend=%0d want 2 1 12",
                  e, stops - s0, location_end_out);
      end
      vecs++;
      if (rec_qpos !== 8'd4 || rec_dbpos !== 32'd1285 || hit_count !== 32'd1) begin
         errs++;
         $display("FAIL rst_after_rec: got q=%0d d=%0d cnt=%0d want 4 1285 1",
                  rec_qpos, rec_dbpos, hit_count);
      end
      vecs++;
   endtask

   initial begin
      test_reset();
      test_single();
      test_hold();
      test_full();
      test_wrap();
      test_clear();
      test_rst_mid_push();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule

// File: doc/hit_collector.md
Name: hit_collector

Overview:
- Sits directly downstream of the seed-hit detector.
- Registers each hit the detector reports (query location, shift count) and turns it into a {query position, database position} record.
- Releases the detector from its hit-hold state by pulsing stop with a resume location.
- Buffers records in a FIFO and presents them to the ungapped-extension stage over a valid/ready handshake.

Parameters:
- DEPTH, 16, FIFO entries (power of two, ≥2)
- QLOC_W, 9, width of query bit-location and shift-count inputs
- DBIDX_W, 32, width of database 512-bit word index
- CNT_W, 32, width of hit counter

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- clear  in  1  synchronous flush of FIFO and counter, active-high
- hit_in  in  1  hit flag from detector
- loc_q_in  in  QLOC_W  query bit location of hit (even)
- shift_no_in  in  QLOC_W  current database shift count in bits (even)
- db_word_idx  in  DBIDX_W  index of 512-bit database word in shift register
- stop_out  out  1  one-cycle release pulse to detector
- location_end_out  out  32  resume shift count sent with stop
- rec_valid  out  1  record available
- rec_ready  in  1  consumer accepts record
- rec_qpos  out  QLOC_W-1  query base position
- rec_dbpos  out  DBIDX_W  database base position
- fifo_full  out  1  FIFO holds DEPTH entries
- hit_count  out  CNT_W  records pushed since reset/clear

Behaviour:
- Reset (rst low, asynchronous): state IDLE, FIFO empty; all outputs 0.
- Position arithmetic, computed at capture:
  - qpos = loc_q_in[QLOC_W-1:1]
  - dbpos = db_word_idx*256 + shift_no_in[QLOC_W-1:1], truncated to DBIDX_W
  - resume = (shift_no_in + 2) mod 2^QLOC_W, zero-extended to 32 bits
- FSM states IDLE, PUSH, WAIT_LOW:
  - IDLE: edge sampling hit_in=1 captures qpos, dbpos, resume → PUSH.
  - PUSH, space available (count<DEPTH, or pop on the same edge): write record, hit_count+1, stop_out<=1, location_end_out<=resume → WAIT_LOW.
  - PUSH, no space: hold the captured record, stop_out stays 0, remain in PUSH. This stalls the detector, which holds hit until stop.
  - WAIT_LOW: stop_out<=0 on the first edge; return to IDLE on the edge sampling hit_in=0. A hit held high produces exactly one record.
- stop_out is registered and high for exactly one cycle per record.
- location_end_out holds its value until the next push.
- FIFO is first-word-fall-through:
  - rec_valid = count≠0; rec_qpos/rec_dbpos show the head entry.
  - Pop when rec_valid && rec_ready.
  - Record visible on outputs the cycle after the push edge, so capture-to-output latency is 2 edges.
- Simultaneous push and pop when full: both occur, count unchanged.
- Pop when empty: ignored.
- clear:
  - Empties FIFO and zeroes hit_count on the next edge.
  - Forces state IDLE and stop_out 0.
  - Has priority over push and pop.
- hit_count saturates at all-ones.
- Reset asserted mid-PUSH: the captured record is discarded and no stop is issued.

Decomposition:
- Package blast_hit_pkg:
  - state enum
  - BASES_PER_WORD=256
  - record width constant
  - hit record struct {qpos, dbpos}
- Sub-module hit_fifo: synchronous FWFT FIFO, parameterised depth/width, with push, pop, full, empty, count and clear. It is reusable by the extension stage.

Test Plan:
- Single hit: loc_q_in=10, shift_no_in=6, db_word_idx=3, rec_ready=1 → one stop pulse, location_end_out=8, record qpos=5 dbpos=771, hit_count=1.
- hit_in held high 10 cycles → exactly one record, one stop pulse, hit_count=1.
- DEPTH=4, rec_ready=0, 5 hits:
  - Fifth hit → FSM stays in PUSH, no stop, fifo_full=1.
  - Pulse rec_ready for one cycle → simultaneous pop/push, stop pulses, count stays 4.
- shift_no_in=510 → location_end_out=0 (wrap); db_word_idx=0xFFFFFFFF, shift_no_in=2 → dbpos=0x00000000+... truncated value checked against model.
- 3 records buffered, assert clear → rec_valid=0 and hit_count=0 after next edge, FSM IDLE.
- Assert rst low while in PUSH → all outputs 0 immediately without a clock; after release, a new hit is processed normally.
